// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle between NUM_MASTERS masters, the round-robin arbiter and one slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_MASTERS = 2
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SW-1:0]         m_sel_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [DATA_WIDTH-1:0]             m_dat_o;

  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SW-1:0]                     s_sel_o;
  logic                              s_ack_i;
  logic [DATA_WIDTH-1:0]             s_dat_i;

  logic                              grant_valid_o;
  logic [GW-1:0]                     grant_idx_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output grant_valid_o, grant_idx_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  grant_valid_o, grant_idx_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Wishbone classic round-robin arbiter: one owner at a time, bus locked while the owner holds cyc,
// and a direct hand-over to the next requester at release.
module wb_rr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_MASTERS = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  wb_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [GW-1:0] grant_idx, grant_next;
  logic [GW-1:0] last_ptr, last_next;
  logic [GW-1:0] rr_winner, cand;
  logic          rr_found;
  logic          grant_valid;

  logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [SW-1:0]         sel_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign adr_arr[i] = bus.m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[i] = bus.m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[i] = bus.m_sel_i[i*SW +: SW];
  end

  // Search starts one past the last winner; the releasing owner drops out because its cyc is low.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(last_ptr) + k) % NUM_MASTERS);
      if (!rr_found && bus.m_cyc_i[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_ptr  <= LAST_RST;
    end else begin
      state     <= state_next;
      grant_idx <= grant_next;
      last_ptr  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    last_next  = last_ptr;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_next = BUSY;
          grant_next = rr_winner;
          last_next  = rr_winner;
        end
      end
      BUSY: begin
        if (!bus.m_cyc_i[grant_idx]) begin
          if (rr_found) begin
            grant_next = rr_winner;
            last_next  = rr_winner;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  assign grant_valid       = (state == BUSY);
  assign bus.grant_valid_o = grant_valid;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.m_dat_o       = bus.s_dat_i;

  // Everything seen by the slave is forced to zero while nobody owns the bus.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    if (grant_valid) begin
      bus.s_cyc_o            = bus.m_cyc_i[grant_idx];
      bus.s_stb_o            = bus.m_stb_i[grant_idx];
      bus.s_we_o             = bus.m_we_i[grant_idx];
      bus.s_adr_o            = adr_arr[grant_idx];
      bus.s_dat_o            = dat_arr[grant_idx];
      bus.s_sel_o            = sel_arr[grant_idx];
      bus.m_ack_o[grant_idx] = bus.s_ack_i;
    end
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Wishbone classic arbiter placed directly upstream of the SRAM controller.
- Accepts NUM_MASTERS master ports (e.g. instruction fetch, data access, DMA) and grants exactly one at a time to a single slave port.
- The granted master keeps the bus for as long as its cyc stays high (bus lock); the arbiter re-arbitrates when cyc drops.
- Masters are selected by round-robin priority.

Parameters:
- DATA_WIDTH, 32, Wishbone data width.
- ADDR_WIDTH, 32, Wishbone address width.
- NUM_MASTERS, 2, number of master ports (2..8).
- GW (localparam), $clog2(NUM_MASTERS), width of the grant index.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master cyc; bit i belongs to master i.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave stb.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_sel_o  out  DATA_WIDTH/8  slave byte selects.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  DATA_WIDTH  slave read data.
- grant_valid_o  out  1  a master currently owns the bus.
- grant_idx_o  out  GW  index of the owning master.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, grant_valid_o=0, grant_idx_o=0, last-grant pointer=NUM_MASTERS-1 (so master 0 has top priority after reset).
- Output values while no grant:
  - s_cyc_o, s_stb_o, s_we_o = 0.
  - s_adr_o, s_dat_o, s_sel_o = 0.
  - m_ack_o = 0.
- State machine, two states, registered:
  - IDLE: if any m_cyc_i bit is high, choose the winner by round-robin and go to BUSY at the next edge. grant_idx_o = winner, grant_valid_o=1, last pointer = winner.
  - BUSY: stay in BUSY while m_cyc_i[grant_idx_o]=1.
  - BUSY with m_cyc_i[grant_idx_o]=0 and another cyc pending: grant the next winner directly at that edge, with no IDLE bubble.
  - BUSY with m_cyc_i[grant_idx_o]=0 and no other cyc pending: go to IDLE, grant_valid_o=0 (grant_idx_o holds its value).
- Round-robin rule:
  - Search starts at (last+1) mod NUM_MASTERS and wraps around.
  - The first master with cyc high wins.
  - The current owner is naturally excluded at release because its cyc is low.
- Grant latency: request at edge N gives grant_valid_o=1 after edge N+1. The slave sees stb in the same cycle the grant is registered.
- Slave-side muxing (combinational from the registered grant):
  - s_cyc_o = grant_valid_o & m_cyc_i[g]; s_stb_o = grant_valid_o & m_stb_i[g].
  - s_we_o, s_adr_o, s_dat_o, s_sel_o are taken from master g's slices.
  - Here g = grant_idx_o.
- Return path:
  - m_ack_o[i] = s_ack_i & grant_valid_o & (g==i).
  - m_dat_o = s_dat_i, unconditionally.
  - Non-granted masters never see ack, regardless of s_ack_i.
- Bus lock: a master that holds cyc across several stb/ack transfers keeps the grant for all of them. Starvation of the other masters is accepted by design.
- Master protocol: masters hold cyc and stb until their ack arrives.
  - A master that drops cyc before ack still causes release.
  - The slave's in-flight operation is not aborted.
  - A stray s_ack_i while IDLE is dropped.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronously), the grant is lost, and the pointer is reset.
- Simultaneous requests after reset: master 0 wins, then 1, and so on.

Test Plan:
1. Single request: reset, then master 1 asserts cyc/stb/we=0, adr=0x8000_0010 → grant_idx_o=1 one edge later; s_adr_o=0x8000_0010; the slave's ack is routed to m_ack_o=2'b10 only, and m_dat_o equals s_dat_i=0xDEAD_BEEF.
2. Contention after reset: masters 0 and 1 assert cyc in the same cycle → master 0 is granted first. When master 0 drops cyc, master 1 is granted at that same edge with no idle cycle. grant_idx_o sequence is 0,1.
3. Fairness: both masters continuously re-request after each single-transfer cycle, for 8 transfers → grants alternate 0,1,0,1,...; each master receives exactly 4 acks.
4. Bus lock: master 0 holds cyc for 3 back-to-back writes (sel=4'b0011, dat=0x0000_1234) while master 1 requests → master 1 receives no grant until master 0's cyc drops. s_sel_o=4'b0011 throughout.
5. Isolation: while master 0 owns the bus, master 1 drives adr=0xFFFF_FFFC and stb=1 → s_adr_o never shows 0xFFFF_FFFC and m_ack_o[1] stays 0.
6. Async reset while BUSY with stb high → s_cyc_o=0, s_stb_o=0, grant_valid_o=0 before the next clock edge. After release, a request from master 0 is granted first.
